multi_sprite_mover: RTL and testbench
=====================================

MULTI_SPRITE_MOVER -- requirements
Module: multi_sprite_mover

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 2, number of independently moved sprites (legal 1..8).
REQ-002 SHALL have parameter NUM_KEYS, default 8, number of 8-bit USB keycode lanes examined.
REQ-003 SHALL have parameter COORD_W, default 10, coordinate width in bits.
REQ-004 SHALL have parameters X_MAX 639, Y_MAX 479, SIZE 16, STEP 2: screen limits, sprite edge length in pixels, pixels moved per frame.
REQ-005 SHALL have parameter KEYMAP, NUM_SPRITES*32 bits, {up,down,left,right} keycodes per sprite, sprite 0 in LSBs; default sprite0 {8'h1A,8'h16,8'h04,8'h07} (WASD), sprite1 {8'h52,8'h51,8'h50,8'h4F} (arrows).
REQ-006 SHALL have parameters START_X, START_Y, NUM_SPRITES*COORD_W bits each, per-sprite reset position; default sprite0 (100,200), sprite1 (500,200).
REQ-007 clk  input  1  system clock; all state on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 vs_in  input  1  raw VGA vsync, asynchronous to clk.
REQ-010 enable  input  1  when low, frame ticks are ignored (pause).
REQ-011 keycodes  input  NUM_KEYS*8  packed keycode lanes, lane 0 in LSBs.
REQ-012 pos_x  output  NUM_SPRITES*COORD_W  packed sprite X positions (top-left).
REQ-013 pos_y  output  NUM_SPRITES*COORD_W  packed sprite Y positions (top-left).
REQ-014 busy  output  1  high while the update sequencer is walking sprites.
REQ-015 frame_done  output  1  one-cycle pulse when all sprites are updated for a frame.

Function
REQ-016 SHALL pass vs_in through a two-flop synchronizer plus one history flop; frame tick = stage2 high and history low (rising edge), one cycle wide.
REQ-017 SHALL start an update only on a frame tick with enable high and sequencer in IDLE; ticks during busy or with enable low are dropped, never queued.
REQ-018 SHALL capture keycodes into a snapshot register in the tick cycle; all sprites of that frame use the snapshot.
REQ-019 Direction d of sprite i SHALL be pressed iff its KEYMAP code is nonzero and equals any snapshot lane.
REQ-020 Sequencer states IDLE -> UPDATE -> DONE -> IDLE; UPDATE processes sprite index 0..NUM_SPRITES-1, one per cycle; DONE lasts exactly one cycle.
REQ-021 busy SHALL be high in UPDATE and DONE; frame_done SHALL be high only in DONE.
REQ-022 Sprite i SHALL update on the clock edge ending the (i+1)th UPDATE cycle; positions of unprocessed sprites hold.
REQ-023 Up and down both pressed SHALL give no Y change; left and right both pressed SHALL give no X change; diagonals apply both axes.
REQ-024 Arithmetic SHALL use COORD_W+1-bit intermediates; no wrap-around.
REQ-025 Move left: if x < STEP then x=0 else x-=STEP; up identical on y.
REQ-026 Move right: if x+STEP > X_MAX+1-SIZE then x=X_MAX+1-SIZE else x+=STEP; down identical with Y_MAX.
REQ-027 Unpressed axes and disabled frames SHALL leave positions unchanged.

Reset
REQ-028 While reset high: pos_x/pos_y = START_X/START_Y, state IDLE, busy 0, frame_done 0, snapshot 0, synchronizer and history flops 0.
REQ-029 Reset asserted mid-UPDATE SHALL abort the frame immediately with no partial further updates; after release, the first tick requires a new vs_in rising edge (no spurious tick from flops cleared to 0 if vs_in already high... a tick SHALL occur only after stage2 goes 0->1).

Verification
REQ-030 Reset, vs_in rising, keycodes lane3=8'h07 -> sprite0 x 100->102, sprite1 unchanged, frame_done pulses once, busy high exactly NUM_SPRITES+1 cycles.
REQ-031 Sprite0 x=1, key 8'h04 held, two frames -> x=0 then x=0 (clamp); sprite1 x=623, key 8'h4F -> x stays 624 max (X_MAX+1-SIZE).
REQ-032 Keys 8'h1A and 8'h16 both in lanes -> sprite0 y unchanged; 8'h1A and 8'h07 -> y-2 and x+2.
REQ-033 enable low during tick -> no busy, no frame_done, positions unchanged; keycodes changed during UPDATE -> result follows snapshot taken at tick.
REQ-034 Reset pulsed during UPDATE after sprite0 moved -> all positions return to START values, busy 0; next update only after fresh vs_in rising edge.
REQ-035 NUM_SPRITES=4, NUM_KEYS=6 build -> each sprite moves per its KEYMAP, frame_done 5 cycles after tick.

Source files
------------

// File: rtl/multi_sprite_mover.sv
// multi_sprite_mover: per-frame keyboard-driven movement of several sprites.
// A vsync rising edge starts a walk over the sprites, one sprite per cycle.
module multi_sprite_mover #(
  parameter int NUM_SPRITES = 2,
  parameter int NUM_KEYS    = 8,
  parameter int COORD_W     = 10,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int SIZE        = 16,
  parameter int STEP        = 2,
  parameter logic [NUM_SPRITES*32-1:0] KEYMAP =
    {8'h52, 8'h51, 8'h50, 8'h4F,
     8'h1A, 8'h16, 8'h04, 8'h07},
  parameter logic [NUM_SPRITES*COORD_W-1:0] START_X =
    {10'd500, 10'd100},
  parameter logic [NUM_SPRITES*COORD_W-1:0] START_Y =
    {10'd200, 10'd200}
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           vs_in,
  input  logic                           enable,
  input  logic [NUM_KEYS*8-1:0]          keycodes,
  output logic [NUM_SPRITES*COORD_W-1:0] pos_x,
  output logic [NUM_SPRITES*COORD_W-1:0] pos_y,
  output logic                           busy,
  output logic                           frame_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_DONE
  } state_t;

  localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_SPRITES - 1);
  localparam logic [COORD_W:0] STEP_W = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0] XLIM_W = (COORD_W+1)'(X_MAX + 1 - SIZE);
  localparam logic [COORD_W:0] YLIM_W = (COORD_W+1)'(Y_MAX + 1 - SIZE);

  logic                           vs_s1_q, vs_s2_q, vs_h_q;
  logic [1:0]                     fill_q;
  logic                           arm_q;
  logic                           tick;
  state_t                         state_q;
  logic [IW-1:0]                  idx_q;
  logic [NUM_KEYS*8-1:0]          snap_q;
  logic [NUM_SPRITES*COORD_W-1:0] px_q, py_q;
  logic [NUM_SPRITES*COORD_W-1:0] px_d, py_d;
  logic                           busy_q, done_q;
  logic [31:0]                    km;
  logic                           k_up, k_dn, k_lf, k_rt;
  logic [COORD_W:0]               cx, cy, nx, ny;

  // A tick only counts once the synchronizer holds real samples and
  // stage2 has been seen low, so a vsync already high at reset release
  // cannot masquerade as a rising edge.
  assign tick = vs_s2_q & ~vs_h_q & arm_q;

  // vsync synchronizer, history flop and post-reset arming
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_s1_q <= 1'b0;
      vs_s2_q <= 1'b0;
      vs_h_q  <= 1'b0;
      fill_q  <= 2'd0;
      arm_q   <= 1'b0;
    end else begin
      vs_s1_q <= vs_in;
      vs_s2_q <= vs_s1_q;
      vs_h_q  <= vs_s2_q;
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      if (fill_q == 2'd2 && !vs_s2_q) arm_q <= 1'b1;
    end
  end

  function automatic logic key_hit(
    input logic [7:0]          code,
    input logic [NUM_KEYS*8-1:0] lanes
  );
    logic h;
    h = 1'b0;
    for (int l = 0; l < NUM_KEYS; l++) begin
      if (code != 8'h00 && lanes[l*8 +: 8] == code) h = 1'b1;
    end
    return h;
  endfunction

  // Direction decode and clamped next position for the current sprite
  always_comb begin
    km   = KEYMAP[int'(idx_q)*32 +: 32];
    k_up = key_hit(km[31:24], snap_q);
    k_dn = key_hit(km[23:16], snap_q);
    k_lf = key_hit(km[15:8],  snap_q);
    k_rt = key_hit(km[7:0],   snap_q);
    cx   = {1'b0, px_q[int'(idx_q)*COORD_W +: COORD_W]};
    cy   = {1'b0, py_q[int'(idx_q)*COORD_W +: COORD_W]};
    nx   = cx;
    ny   = cy;
    if (k_lf && !k_rt) begin
      nx = (cx < STEP_W) ? '0 : cx - STEP_W;
    end else if (k_rt && !k_lf) begin
      nx = (cx + STEP_W > XLIM_W) ? XLIM_W : cx + STEP_W;
    end
    if (k_up && !k_dn) begin
      ny = (cy < STEP_W) ? '0 : cy - STEP_W;
    end else if (k_dn && !k_up) begin
      ny = (cy + STEP_W > YLIM_W) ? YLIM_W : cy + STEP_W;
    end
    px_d = px_q;
    py_d = py_q;
    px_d[int'(idx_q)*COORD_W +: COORD_W] = COORD_W'(nx);
    py_d[int'(idx_q)*COORD_W +: COORD_W] = COORD_W'(ny);
  end

  // Update sequencer: IDLE -> UPDATE (one sprite per cycle) -> DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      px_q    <= START_X;
      py_q    <= START_Y;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (tick && enable) begin
            snap_q  <= keycodes;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          px_q <= px_d;
          py_q <= py_d;
          if (idx_q == LAST) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pos_x      = px_q;
  assign pos_y      = py_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_multi_sprite_mover.sv
// tb_multi_sprite_mover: directed vectors for multi_sprite_mover.
// Three builds: default, 4-sprite/6-lane, and one started near the edges.
module tb_multi_sprite_mover;

  logic clk = 1'b0;
  logic reset, vs_in, enable, en3;
  logic [63:0] keys;
  logic [47:0] keys4;
  logic [19:0] px1, py1, px3, py3;
  logic [39:0] px2, py2;
  logic busy1, fd1, busy2, fd2, busy3, fd3;

  int n_chk = 0;
  int n_bad = 0;
  int nb1, nf1, nb2, fat1, fat2, n;

  always #5 clk = ~clk;

  multi_sprite_mover u_dut1 (
    .clk(clk), .reset(reset), .vs_in(vs_in), .enable(enable),
    .keycodes(keys), .pos_x(px1), .pos_y(py1),
    .busy(busy1), .frame_done(fd1)
  );

  multi_sprite_mover #(
    .NUM_SPRITES(4), .NUM_KEYS(6),
    .KEYMAP({8'h60, 8'h5A, 8'h5C, 8'h5E,
             8'h0C, 8'h0E, 8'h0D, 8'h0F,
             8'h52, 8'h51, 8'h50, 8'h4F,
             8'h1A, 8'h16, 8'h04, 8'h07}),
    .START_X({10'd0, 10'd300, 10'd500, 10'd100}),
    .START_Y({10'd0, 10'd100, 10'd200, 10'd200})
  ) u_dut2 (
    .clk(clk), .reset(reset), .vs_in(vs_in), .enable(enable),
    .keycodes(keys4), .pos_x(px2), .pos_y(py2),
    .busy(busy2), .frame_done(fd2)
  );

  multi_sprite_mover #(
    .START_X({10'd623, 10'd1})
  ) u_dut3 (
    .clk(clk), .reset(reset), .vs_in(vs_in), .enable(en3),
    .keycodes(keys), .pos_x(px3), .pos_y(py3),
    .busy(busy3), .frame_done(fd3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One vsync pulse; counts busy/frame_done samples, optional key swap
  // in the first UPDATE cycle (sample 3).
  task automatic frame(input bit use_mid, input logic [63:0] mid);
    nb1 = 0; nf1 = 0; nb2 = 0; fat1 = 0; fat2 = 0;
    vs_in = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (busy1) nb1++;
      if (fd1) begin
        nf1++;
        if (fat1 == 0) fat1 = k;
      end
      if (busy2) nb2++;
      if (fd2 && fat2 == 0) fat2 = k;
      if (use_mid && k == 3) keys = mid;
      if (k == 8) vs_in = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; vs_in = 1'b0; enable = 1'b1; en3 = 1'b0;
    keys = '0; keys4 = '0;
    repeat (3) @(negedge clk);
    chk("rst_x0", px1[9:0], 100);
    chk("rst_y0", py1[9:0], 200);
    chk("rst_x1", px1[19:10], 500);
    chk("rst_y1", py1[19:10], 200);
    chk("rst_busy", busy1, 0);
    chk("rst_fd", fd1, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // lane3 = D: sprite0 right
    keys = 64'h07 << 24;
    frame(0, '0);
    chk("r_x0", px1[9:0], 102);
    chk("r_y0", py1[9:0], 200);
    chk("r_x1", px1[19:10], 500);
    chk("r_nb", nb1, 3);
    chk("r_nf", nf1, 1);
    chk("r_fat", fat1, 5);

    // W and S together cancel
    keys = 64'h1A | (64'h16 << 40);
    frame(0, '0);
    chk("ud_y0", py1[9:0], 200);
    chk("ud_x0", px1[9:0], 102);

    // W + D diagonal
    keys = (64'h1A << 8) | 64'h07;
    frame(0, '0);
    chk("dg_y0", py1[9:0], 198);
    chk("dg_x0", px1[9:0], 104);

    // paused frame
    enable = 1'b0;
    keys = 64'h07;
    frame(0, '0);
    chk("en_nb", nb1, 0);
    chk("en_nf", nf1, 0);
    chk("en_x0", px1[9:0], 104);
    enable = 1'b1;

    // keys swapped mid-walk: snapshot (D only) wins
    keys = 64'h07;
    frame(1, 64'h04 | (64'h4F << 8));
    chk("sn_x0", px1[9:0], 106);
    chk("sn_x1", px1[19:10], 500);

    // edge clamps: A for sprite0, right arrow for sprite1
    en3 = 1'b1;
    keys = 64'h04 | (64'h4F << 8);
    frame(0, '0);
    chk("cl_l1", px3[9:0], 0);
    chk("cl_r1", px3[19:10], 624);
    frame(0, '0);
    chk("cl_l2", px3[9:0], 0);
    chk("cl_r2", px3[19:10], 624);
    chk("cl_x0", px1[9:0], 102);
    chk("cl_x1", px1[19:10], 504);
    en3 = 1'b0;

    // four-sprite build
    keys = '0;
    keys4 = 48'h5E_60_0D_51_07;
    frame(0, '0);
    chk("m4_x0", px2[9:0], 102);
    chk("m4_y1", py2[19:10], 202);
    chk("m4_x2", px2[29:20], 298);
    chk("m4_x3", px2[39:30], 2);
    chk("m4_y3", py2[39:30], 0);
    chk("m4_nb", nb2, 5);
    chk("m4_fat", fat2, 7);
    chk("m4_d1x", px1[9:0], 102);
    keys4 = '0;

    // reset mid-walk after sprite0 moved
    keys = 64'h07 | (64'h50 << 8);
    vs_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("ra_x0", px1[9:0], 104);
    chk("ra_x1", px1[19:10], 504);
    chk("ra_busy", busy1, 1);
    reset = 1'b1;
    #1;
    chk("ra_rx0", px1[9:0], 100);
    chk("ra_rx1", px1[19:10], 500);
    chk("ra_ry0", py1[9:0], 200);
    chk("ra_rbusy", busy1, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy1 || fd1) n++;
    end
    chk("ra_notick", n, 0);
    chk("ra_hold", px1[9:0], 100);
    vs_in = 1'b0;
    repeat (3) @(negedge clk);
    frame(0, '0);
    chk("ra_nx0", px1[9:0], 102);
    chk("ra_nx1", px1[19:10], 498);
    chk("ra_nb", nb1, 3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
